// File: rtl/fifo_write_arbiter_if.sv
// Requester/fifo-side bundle of the fifo write arbiter.
// FIFO_ARB_LOCK_EN adds the per-requester end-of-burst marker req_last.
interface fifo_write_arbiter_if #(
  parameter int W  = 8,
  parameter int IW = 2
);
  localparam int N = 2 ** IW;

  logic [N-1:0]   req;
  logic [N*W-1:0] data;
  logic [N-1:0]   ack;
  logic [IW-1:0]  grant_id;
  logic           busy;
  logic [W-1:0]   fifo_in;
  logic           fifo_put;
  logic           fifo_full;
`ifdef FIFO_ARB_LOCK_EN
  logic [N-1:0]   req_last;

  modport master (
    output req, data, req_last, fifo_full,
    input  ack, grant_id, busy, fifo_in, fifo_put
  );
  modport slave (
    input  req, data, req_last, fifo_full,
    output ack, grant_id, busy, fifo_in, fifo_put
  );
`else
  modport master (
    output req, data, fifo_full,
    input  ack, grant_id, busy, fifo_in, fifo_put
  );
  modport slave (
    input  req, data, fifo_full,
    output ack, grant_id, busy, fifo_in, fifo_put
  );
`endif
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one fifo write port among 2**IW requesters.
// Optional FIFO_ARB_LOCK_EN keeps a requester's burst contiguous until req_last.
module fifo_write_arbiter #(
  parameter int W  = 8,
  parameter int IW = 2
) (
  input  logic                clk,
  input  logic                reset,
  fifo_write_arbiter_if.slave bus
);
  localparam int N = 2 ** IW;

  // Each state names the action taken on the edge that leaves it:
  // IDLE grants and loads fifo_in, STROBE raises put, RELEASE drops it.
  typedef enum logic [1:0] {IDLE, STROBE, RELEASE} state_t;

  state_t        state;
  logic [IW-1:0] last;
  logic [IW-1:0] scan_idx;
  logic [IW-1:0] pick;
  logic          pick_ok;
`ifdef FIFO_ARB_LOCK_EN
  logic          locked;
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    scan_idx = '0;
    pick     = '0;
    pick_ok  = 1'b0;
    for (int k = 1; k <= N; k++) begin
      scan_idx = last + IW'(k);
      if (!pick_ok && bus.req[scan_idx]) begin
        pick    = scan_idx;
        pick_ok = 1'b1;
      end
    end
`ifdef FIFO_ARB_LOCK_EN
    // While a burst is open only its owner (the last grantee) may be served.
    if (locked) begin
      pick    = bus.grant_id;
      pick_ok = bus.req[bus.grant_id];
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      last         <= IW'(N - 1);
      bus.fifo_put <= 1'b0;
      bus.ack      <= '0;
      bus.busy     <= 1'b0;
      bus.fifo_in  <= '0;
      bus.grant_id <= '0;
`ifdef FIFO_ARB_LOCK_EN
      locked       <= 1'b0;
`endif
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      case (state)
        IDLE: begin
          if (pick_ok && !bus.fifo_full) begin
            bus.fifo_in  <= bus.data[pick*W +: W];
            bus.grant_id <= pick;
            bus.busy     <= 1'b1;
`ifdef FIFO_ARB_LOCK_EN
            locked       <= !bus.req_last[pick];
`endif
            state        <= STROBE;
          end
        end
        STROBE: begin
          bus.fifo_put <= 1'b1;
          bus.ack      <= N'(1) << bus.grant_id;
          state        <= RELEASE;
        end
        RELEASE: begin
          bus.fifo_put <= 1'b0;
          bus.ack      <= '0;
          bus.busy     <= 1'b0;
          last         <= bus.grant_id;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter with a 4-word edge-driven fifo model.
// Define FIFO_ARB_LOCK_EN on both RTL and bench to exercise burst locking.
module tb_fifo_write_arbiter;
  localparam int W  = 8;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  fifo_write_arbiter_if #(.W(W), .IW(IW)) bus ();

  fifo_write_arbiter #(.W(W), .IW(IW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Fifo model: word written on rising put, write pointer advances on falling put.
  logic [7:0] fmem [4];
  logic [2:0] wptr = '0;
  logic [2:0] rptr = '0;
  logic       empty;

  assign bus.fifo_full = ((wptr - rptr) == 3'd4);
  assign empty         = (wptr == rptr);

  always @(posedge bus.fifo_put) if (!reset) fmem[wptr[1:0]] = bus.fifo_in;
  always @(negedge bus.fifo_put or posedge reset) begin
    if (reset) wptr = '0;
    else       wptr = wptr + 3'd1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_word(input int i, input logic [7:0] v);
    bus.data[i*W +: W] = v;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    bus.req  = '0;
    bus.data = '0;
`ifdef FIFO_ARB_LOCK_EN
    bus.req_last = '0;
`endif
    rptr = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  // Waits (bounded) for an ack and checks the granted word; ack must come 2 clk after an IDLE sample.
  task automatic expect_word(input string tag, input int idx, input logic [7:0] d);
    int n = 0;
    do begin
      step();
      n++;
    end while (bus.ack == '0 && n < 20);
    check({tag, "_ack"},      bus.ack, 32'(1) << idx);
    check({tag, "_grant"},    bus.grant_id, idx);
    check({tag, "_fifo_in"},  bus.fifo_in, d);
    check({tag, "_put"},      bus.fifo_put, 1);
    check({tag, "_latency"},  n, 2);
  endtask

  task automatic fifo_get(input string tag, input logic [7:0] d);
    check({tag, "_empty"}, empty, 0);
    check({tag, "_data"},  fmem[rptr[1:0]], d);
    rptr = rptr + 3'd1;
  endtask

  initial begin
    int order [5] = '{0, 1, 2, 3, 0};
    int stray;

    // Reset values while reset is held.
    reset = 1'b1;
    bus.req = '0;
    bus.data = '0;
`ifdef FIFO_ARB_LOCK_EN
    bus.req_last = '0;
`endif
    step();
    check("rst_put",   bus.fifo_put, 0);
    check("rst_ack",   bus.ack, 0);
    check("rst_busy",  bus.busy, 0);
    check("rst_in",    bus.fifo_in, 0);
    check("rst_grant", bus.grant_id, 0);

    // 1: single word, cycle by cycle.
    do_reset();
    bus.req = 4'b0001;
    set_word(0, 8'hA5);
    step();
    check("t1_busy",   bus.busy, 1);
    check("t1_in",     bus.fifo_in, 8'hA5);
    check("t1_put0",   bus.fifo_put, 0);
    check("t1_ack0",   bus.ack, 0);
    step();
    check("t1_put1",   bus.fifo_put, 1);
    check("t1_ack1",   bus.ack, 4'b0001);
    step();
    check("t1_put2",   bus.fifo_put, 0);
    check("t1_ack2",   bus.ack, 0);
    check("t1_busy2",  bus.busy, 0);
    bus.req = '0;
    fifo_get("t1_rd", 8'hA5);

    // 2: all requesting -> 0,1,2,3,0, one word per 3 clk.
    do_reset();
    for (int i = 0; i < 4; i++) set_word(i, 8'h10 + 8'(i));
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      expect_word("t2", order[k], 8'h10 + 8'(order[k]));
      step();
      fifo_get("t2_rd", 8'h10 + 8'(order[k]));
    end
    bus.req = '0;

    // 3: fifo fills after 4 words; nothing is put while full; one get frees a slot.
    do_reset();
    bus.req = 4'b0001;
    set_word(0, 8'h30);
    for (int k = 0; k < 4; k++) begin
      expect_word("t3", 0, 8'h30 + 8'(k));
      step();
      set_word(0, 8'h31 + 8'(k));
    end
    check("t3_full", bus.fifo_full, 1);
    stray = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (bus.fifo_put || (bus.ack != '0)) stray++;
    end
    check("t3_hold", stray, 0);
    fifo_get("t3_rd", 8'h30);
    expect_word("t3_5th", 0, 8'h34);
    step();
    check("t3_full2", bus.fifo_full, 1);
    bus.req = '0;

    // 4: reset while put is high drops put/ack at once; next grant goes to requester 0.
    do_reset();
    bus.req = 4'b0010;
    set_word(1, 8'h41);
    expect_word("t4_pre", 1, 8'h41);
    step();
    set_word(1, 8'h42);
    @(posedge clk);
    @(posedge clk);
    #2;
    check("t4_put_hi", bus.fifo_put, 1);
    reset = 1'b1;
    #1;
    check("t4_put", bus.fifo_put, 0);
    check("t4_ack", bus.ack, 0);
    check("t4_busy", bus.busy, 0);
    check("t4_empty", empty, 1);
    step();
    reset = 1'b0;
    rptr = '0;
    for (int i = 0; i < 4; i++) set_word(i, 8'h70 + 8'(i));
    bus.req = 4'b1111;
    expect_word("t4_post", 0, 8'h70);
    bus.req = '0;
    step();

    // 5: last=2, requesters 3 and 0 -> 3 first, then 0.
    do_reset();
    bus.req = 4'b0100;
    set_word(2, 8'h52);
    expect_word("t5_pre", 2, 8'h52);
    step();
    set_word(3, 8'h63);
    set_word(0, 8'h60);
    bus.req = 4'b1001;
    expect_word("t5_a", 3, 8'h63);
    step();
    bus.req = 4'b0001;
    expect_word("t5_b", 0, 8'h60);
    bus.req = '0;
    step();

`ifdef FIFO_ARB_LOCK_EN
    // 6: requester 0 burst of 3 stays contiguous ahead of requester 1.
    do_reset();
    set_word(0, 8'hA0);
    set_word(1, 8'hB0);
    bus.req_last = 4'b0010;
    bus.req = 4'b0011;
    expect_word("t6_w0", 0, 8'hA0);
    step();
    set_word(0, 8'hA1);
    expect_word("t6_w1", 0, 8'hA1);
    step();
    set_word(0, 8'hA2);
    bus.req_last = 4'b0011;
    expect_word("t6_w2", 0, 8'hA2);
    step();
    bus.req = 4'b0010;
    expect_word("t6_r1", 1, 8'hB0);
    bus.req = '0;
    step();
    fifo_get("t6_rd0", 8'hA0);
    fifo_get("t6_rd1", 8'hA1);
    fifo_get("t6_rd2", 8'hA2);
    fifo_get("t6_rd3", 8'hB0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
